// File: rtl/qos_vc_router_if.sv
// Ingress/egress and counter-read bundle of the QoS virtual-channel router.
interface qos_vc_router_if #(
    parameter int DATA_W = 12,
    parameter int CH     = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 5
);
    logic                       push;
    logic [DATA_W-1:0]          data_in;
    logic [CH-1:0]              pop;
    logic [CH-1:0][DATA_W-1:0]  data_out;
    logic [CH-1:0]              empty;
    logic [CH-1:0]              almost_full;
    logic [CH-1:0]              almost_empty;
    logic                       pause;
    logic                       req;
    logic [CH_W:0]              idx;
    logic                       valid;
    logic [CNT_W-1:0]           data;

    modport master (
        output push, data_in, pop, req, idx,
        input  data_out, empty, almost_full, almost_empty, pause, valid, data
    );
    modport slave (
        input  push, data_in, pop, req, idx,
        output data_out, empty, almost_full, almost_empty, pause, valid, data
    );
endinterface

// File: rtl/qos_vc_router.sv
// QoS VC router: per-channel show-ahead FIFOs with threshold flags, hysteretic
// pause, saturating push counters and a RESET/INIT/IDLE/ACTIVE/ERROR controller.
module qos_vc_lane #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W:0]    hi,
    input  logic [PTR_W:0]    lo,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              drop,
    output logic [CNT_W-1:0]  count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W:0]    occ;
    logic              full, accept, rd;

    assign full   = (occ == (PTR_W+1)'(DEPTH));
    assign empty  = (occ == '0);
    // A pop on a full channel frees the slot the same-cycle push lands in.
    assign accept = push && (!full || pop);
    assign rd     = pop && !empty;
    assign drop   = push && full && !pop;

    assign head         = mem[rptr];
    assign almost_full  = (occ >= hi);
    assign almost_empty = (occ <= lo);

    always_ff @(posedge clk) begin
        if (!flush && accept) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (rd)     rptr <= rptr + 1'b1;
            occ <= occ + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, rd};
            if (accept && count != CNT_MAX) count <= count + 1'b1;
        end
    end
endmodule

module qos_vc_router #(
    parameter int DATA_W = 12,
    parameter int CH     = 4,
    parameter int CH_W   = 2,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [PTR_W:0]       umbralHigh,
    input  logic [PTR_W:0]       umbralLow,
    qos_vc_router_if.slave       bus,
    output logic                 active_out,
    output logic                 idle_out,
    output logic                 error_out
);
    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    localparam logic [PTR_W:0] HI_DEF = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] LO_DEF = (PTR_W+1)'(1);

    state_t                    state, nxt;
    logic                      run, flush;
    logic [CH_W-1:0]           ch;
    logic [PTR_W:0]            hi, lo;
    logic [CH-1:0][DATA_W-1:0] head;
    logic [CH-1:0]             empty, af, ae, drop;
    logic [CH-1:0][CNT_W-1:0]  cnt;
    logic                      rd_ok;

    assign run   = (state == S_IDLE) || (state == S_ACTIVE) || (state == S_ERROR);
    assign flush = reset || !run;
    assign ch    = bus.data_in[DATA_W-1 -: CH_W];

    for (genvar i = 0; i < CH; i++) begin : g_lane
        qos_vc_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_lane (
            .clk         (clk),
            .flush       (flush),
            .push        (run && bus.push && (ch == CH_W'(i))),
            .pop         (run && bus.pop[i]),
            .wdata       (bus.data_in),
            .hi          (hi),
            .lo          (lo),
            .head        (head[i]),
            .empty       (empty[i]),
            .almost_full (af[i]),
            .almost_empty(ae[i]),
            .drop        (drop[i]),
            .count       (cnt[i])
        );
    end

    assign bus.data_out     = head;
    assign bus.empty        = empty;
    assign bus.almost_full  = af;
    assign bus.almost_empty = ae;

    // Thresholds track the inputs through INIT; a bad pair on exit falls back to defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= HI_DEF;
            lo <= LO_DEF;
        end else if (state == S_INIT) begin
            if (!init && (umbralLow >= umbralHigh || umbralHigh > (PTR_W+1)'(DEPTH))) begin
                hi <= HI_DEF;
                lo <= LO_DEF;
            end else begin
                hi <= umbralHigh;
                lo <= umbralLow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    bus.pause <= 1'b0;
        else if (|af) bus.pause <= 1'b1;
        else if (&ae) bus.pause <= 1'b0;
    end

    assign rd_ok = bus.req && (bus.idx < (CH_W+1)'(CH));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid <= 1'b0;
            bus.data  <= '0;
        end else begin
            bus.valid <= rd_ok;
            if (rd_ok) bus.data <= cnt[bus.idx[CH_W-1:0]];
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RESET: nxt = S_INIT;
            S_INIT:  if (!init) nxt = S_IDLE;
            S_IDLE, S_ACTIVE: begin
                if (init)                                       nxt = S_INIT;
                else if (|drop)                                 nxt = S_ERROR;
                else if (state == S_IDLE && bus.push)           nxt = S_ACTIVE;
                else if (state == S_ACTIVE && &empty && !bus.push) nxt = S_IDLE;
            end
            S_ERROR: if (init) nxt = S_INIT;
            default: nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RESET;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state      <= nxt;
            idle_out   <= (nxt == S_IDLE);
            active_out <= (nxt == S_ACTIVE);
            error_out  <= (nxt == S_ERROR);
        end
    end
endmodule

// File: tb/tb_qos_vc_router.sv
// Directed bench for qos_vc_router: classification, thresholds, pause, overflow, counters, reset.
module tb_qos_vc_router;
    localparam int DATA_W = 12, CH = 4, CH_W = 2, DEPTH = 8, PTR_W = 3, CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset, init;
    logic [PTR_W:0]   umbralHigh, umbralLow;
    logic             active_out, idle_out, error_out;
    int               errors = 0;
    int               checks = 0;

    qos_vc_router_if #(.DATA_W(DATA_W), .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    qos_vc_router #(.DATA_W(DATA_W), .CH(CH), .CH_W(CH_W), .DEPTH(DEPTH),
                    .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbralHigh(umbralHigh), .umbralLow(umbralLow),
        .bus(bus),
        .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        bus.push = 1'b1; bus.data_in = w;
        tick();
        bus.push = 1'b0;
    endtask

    task automatic pop_ch(input int c);
        bus.pop = CH'(1 << c);
        tick();
        bus.pop = '0;
    endtask

    task automatic read_cnt(input logic [CH_W:0] i);
        bus.req = 1'b1; bus.idx = i;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; umbralHigh = 4'd5; umbralLow = 4'd1;
        tick(); tick();
        checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL rst_empty: got %h expected f", bus.empty); end
        checks++; if (bus.almost_empty !== 4'hF) begin errors++; $display("FAIL rst_ae: got %h expected f", bus.almost_empty); end
        checks++; if ({bus.almost_full, bus.pause, bus.valid, bus.data} !== '0) begin errors++;
            $display("FAIL rst_outs: got af=%h pause=%b valid=%b data=%h expected 0", bus.almost_full, bus.pause, bus.valid, bus.data); end
        checks++; if ({active_out, idle_out, error_out} !== 3'b000) begin errors++;
            $display("FAIL rst_flags: got %b expected 000", {active_out, idle_out, error_out}); end
        reset = 1'b0;
        tick();
        checks++; if (idle_out !== 1'b0) begin errors++; $display("FAIL init_idle: got %b expected 0", idle_out); end
        init = 1'b0;
        tick();
        checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL idle_after_init: got %b expected 1", idle_out); end
        checks++; if (bus.empty !== 4'hF || bus.pause !== 1'b0) begin errors++;
            $display("FAIL idle_state: got empty=%h pause=%b expected f/0", bus.empty, bus.pause); end
    endtask

    task automatic test_classify();
        push_word(12'h0FF); push_word(12'h404); push_word(12'h895); push_word(12'hCAE);
        checks++; if (bus.empty !== 4'h0) begin errors++; $display("FAIL cls_empty: got %h expected 0", bus.empty); end
        checks++; if (bus.data_out[0] !== 12'h0FF || bus.data_out[1] !== 12'h404) begin errors++;
            $display("FAIL cls_head01: got %h %h expected 0ff 404", bus.data_out[0], bus.data_out[1]); end
        checks++; if (bus.data_out[2] !== 12'h895 || bus.data_out[3] !== 12'hCAE) begin errors++;
            $display("FAIL cls_head23: got %h %h expected 895 cae", bus.data_out[2], bus.data_out[3]); end
        checks++; if (active_out !== 1'b1) begin errors++; $display("FAIL cls_active: got %b expected 1", active_out); end
        read_cnt(3'd2);
        checks++; if (bus.valid !== 1'b1 || bus.data !== 5'd1) begin errors++;
            $display("FAIL cnt_idx2: got valid=%b data=%0d expected 1/1", bus.valid, bus.data); end
        read_cnt(3'd4);
        checks++; if (bus.valid !== 1'b0 || bus.data !== 5'd1) begin errors++;
            $display("FAIL cnt_idx4: got valid=%b data=%0d expected 0/1", bus.valid, bus.data); end
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL cnt_noreq: got %b expected 0", bus.valid); end
        bus.pop = 4'hF; tick(); bus.pop = '0;
        checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL cls_drain: got %h expected f", bus.empty); end
        tick();
        checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL back_idle: got %b expected 1", idle_out); end
    endtask

    task automatic test_pause();
        for (int k = 1; k <= 4; k++) push_word(12'(k));
        checks++; if (bus.almost_full !== 4'h0) begin errors++; $display("FAIL af_occ4: got %h expected 0", bus.almost_full); end
        push_word(12'h005);
        checks++; if (bus.almost_full !== 4'h1 || bus.pause !== 1'b0) begin errors++;
            $display("FAIL af_occ5: got af=%h pause=%b expected 1/0", bus.almost_full, bus.pause); end
        tick();
        checks++; if (bus.pause !== 1'b1) begin errors++; $display("FAIL pause_set: got %b expected 1", bus.pause); end
        pop_ch(0); pop_ch(0); pop_ch(0);
        checks++; if (bus.pause !== 1'b1 || bus.almost_full !== 4'h0) begin errors++;
            $display("FAIL pause_hold: got pause=%b af=%h expected 1/0", bus.pause, bus.almost_full); end
        checks++; if (bus.data_out[0] !== 12'h004) begin errors++; $display("FAIL pop_order: got %h expected 004", bus.data_out[0]); end
        pop_ch(0);
        checks++; if (bus.pause !== 1'b1 || bus.almost_empty !== 4'hF) begin errors++;
            $display("FAIL pause_lag: got pause=%b ae=%h expected 1/f", bus.pause, bus.almost_empty); end
        tick();
        checks++; if (bus.pause !== 1'b0) begin errors++; $display("FAIL pause_clr: got %b expected 0", bus.pause); end
        pop_ch(0);
        read_cnt(3'd0);
        checks++; if (bus.data !== 5'd6) begin errors++; $display("FAIL cnt_ch0: got %0d expected 6", bus.data); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) push_word(12'(12'h400 + k));
        checks++; if (bus.almost_full[1] !== 1'b1 || error_out !== 1'b0) begin errors++;
            $display("FAIL full_ch1: got af=%b err=%b expected 1/0", bus.almost_full[1], error_out); end
        push_word(12'h4EE);
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", error_out); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.data_out[1] !== 12'(12'h400 + k)) begin errors++;
                $display("FAIL ovf_order%0d: got %h expected %h", k, bus.data_out[1], 12'(12'h400 + k)); end
            pop_ch(1);
        end
        checks++; if (bus.empty[1] !== 1'b1 || error_out !== 1'b1) begin errors++;
            $display("FAIL ovf_drain: got empty=%b err=%b expected 1/1", bus.empty[1], error_out); end
        pop_ch(1);
        read_cnt(3'd1);
        checks++; if (bus.data !== 5'd9) begin errors++; $display("FAIL cnt_ch1: got %0d expected 9", bus.data); end
        init = 1'b1;
        tick();
        checks++; if ({active_out, idle_out, error_out} !== 3'b000) begin errors++;
            $display("FAIL init_flags: got %b expected 000", {active_out, idle_out, error_out}); end
        tick();
        read_cnt(3'd1);
        checks++; if (bus.data !== 5'd0 || bus.valid !== 1'b1) begin errors++;
            $display("FAIL init_cnt: got valid=%b data=%0d expected 1/0", bus.valid, bus.data); end
        init = 1'b0;
        tick();
        checks++; if (idle_out !== 1'b1 || error_out !== 1'b0) begin errors++;
            $display("FAIL init_exit: got idle=%b err=%b expected 1/0", idle_out, error_out); end
    endtask

    task automatic test_bad_thresholds();
        init = 1'b1; umbralHigh = 4'd3; umbralLow = 4'd3;
        tick();
        init = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) push_word(12'(12'hC00 + k));
        checks++; if (bus.almost_full[3] !== 1'b0 || bus.almost_empty[3] !== 1'b0) begin errors++;
            $display("FAIL thr_occ6: got af=%b ae=%b expected 0/0", bus.almost_full[3], bus.almost_empty[3]); end
        push_word(12'hC06);
        checks++; if (bus.almost_full[3] !== 1'b1) begin errors++; $display("FAIL thr_occ7: got %b expected 1", bus.almost_full[3]); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 8; k++) push_word(12'(12'h800 + k));
        checks++; if (bus.almost_full[2] !== 1'b1) begin errors++; $display("FAIL full_ch2: got %b expected 1", bus.almost_full[2]); end
        bus.push = 1'b1; bus.data_in = 12'h8AA; bus.pop = 4'b0100;
        tick();
        bus.push = 1'b0; bus.pop = '0;
        checks++; if (error_out !== 1'b0 || bus.data_out[2] !== 12'h801) begin errors++;
            $display("FAIL full_pp: got err=%b head=%h expected 0/801", error_out, bus.data_out[2]); end
        for (int k = 0; k < 7; k++) pop_ch(2);
        checks++; if (bus.data_out[2] !== 12'h8AA || bus.empty[2] !== 1'b0) begin errors++;
            $display("FAIL full_pp_tail: got head=%h empty=%b expected 8aa/0", bus.data_out[2], bus.empty[2]); end
        pop_ch(2);
        checks++; if (bus.empty[2] !== 1'b1) begin errors++; $display("FAIL full_pp_drain: got %b expected 1", bus.empty[2]); end
        bus.push = 1'b1; bus.data_in = 12'h8BB; bus.pop = 4'b0100;
        tick();
        bus.push = 1'b0; bus.pop = '0;
        checks++; if (bus.empty[2] !== 1'b0 || bus.data_out[2] !== 12'h8BB) begin errors++;
            $display("FAIL empty_pp: got empty=%b head=%h expected 0/8bb", bus.empty[2], bus.data_out[2]); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; bus.push = 1'b1; bus.data_in = 12'h0FF;
        tick();
        bus.push = 1'b0;
        checks++; if (bus.empty !== 4'hF || bus.almost_empty !== 4'hF || bus.almost_full !== 4'h0) begin errors++;
            $display("FAIL mid_rst_fifo: got empty=%h ae=%h af=%h expected f/f/0", bus.empty, bus.almost_empty, bus.almost_full); end
        checks++; if ({bus.pause, bus.valid, bus.data, active_out, idle_out, error_out} !== '0) begin errors++;
            $display("FAIL mid_rst_outs: got pause=%b valid=%b data=%h flags=%b expected 0", bus.pause, bus.valid, bus.data,
                     {active_out, idle_out, error_out}); end
        reset = 1'b0;
        tick(); tick();
        checks++; if (idle_out !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b expected 1", idle_out); end
        read_cnt(3'd3);
        checks++; if (bus.data !== 5'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", bus.data); end
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; umbralHigh = 4'd7; umbralLow = 4'd1;
        bus.push = 1'b0; bus.data_in = '0; bus.pop = '0; bus.req = 1'b0; bus.idx = '0;
        test_reset();
        test_classify();
        test_pause();
        test_overflow();
        test_bad_thresholds();
        test_full_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
